sample_acquisition_az_seq: RTL and testbench
============================================

Name: sample_acquisition_az_seq

Overview:
Auto-zero sample-acquisition sequencer. It alternates the input between signal (HI) and zero (LO) az-mux positions, and runs a precharge dwell before each sample. For each half it triggers the ADC and waits for the ADC's measure-valid handshake. It sits between the SPI register set and the top-level mode mux, driving the o_u410 az mux, o_sig_pc1_sw/o_sig_pc2_sw and o_meas_complete.

Parameters:
PC_CNT_W, 24, width of precharge count register and counter
AZ_W, 4, width of az mux select
TIMEOUT_W, 32, width of sample-timeout counter (used only with optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
arm  in  1  level; 1 = run auto-zero cycles continuously
p_clk_count_precharge  in  PC_CNT_W  precharge dwell in clk cycles
p_azmux_hi  in  AZ_W  az mux code for signal half
p_azmux_lo  in  AZ_W  az mux code for zero half
p_pc_sel  in  2  one-hot mask of which pc switch(es) close during sample
p_clk_timeout  in  TIMEOUT_W  max wait for adc_measure_valid (optional feature)
adc_measure_valid  in  1  one-cycle pulse from ADC: conversion finished
adc_measure_trig  out  1  one-cycle pulse: start ADC conversion
azmux  out  AZ_W  az mux drive
sw_pc_ctl  out  2  pc switch drive
meas_complete  out  1  one-cycle pulse: HI and LO pair done
az_half  out  1  0 = last completed sample was LO, 1 = HI
status  out  3  current state code
err_timeout  out  1  sticky timeout flag (optional feature; else tied 0)

Behaviour:
- Timing: all outputs are registered.
- Reset values:
  - state IDLE, azmux = 0, sw_pc_ctl = 0.
  - adc_measure_trig = 0, meas_complete = 0, az_half = 0, err_timeout = 0, counters = 0.
- Parameter latching:
  - p_azmux_* and p_pc_sel are latched on exit from IDLE.
  - p_clk_count_precharge is latched on entry to each PRECHARGE state.
  - Changing any of them mid-phase has no effect until the next latch point.
- States (status code):
  - IDLE(0): azmux = 0, sw_pc_ctl = 0. arm=1 -> PRE_HI on the next cycle.
  - PRE_HI(1): azmux = hi, sw_pc_ctl = 0. Dwell = max(count,1) cycles -> SMP_HI.
  - SMP_HI(2): sw_pc_ctl = latched p_pc_sel, azmux = hi.
    - adc_measure_trig pulses in the first cycle in the state.
    - Wait for adc_measure_valid -> PRE_LO; az_half <= 1.
  - PRE_LO(3): azmux = lo, sw_pc_ctl = 0. Dwell = max(count,1) -> SMP_LO.
  - SMP_LO(4): sw_pc_ctl = latched p_pc_sel, azmux = lo.
    - Trig pulse on entry; wait for valid -> DONE; az_half <= 0.
  - DONE(5): meas_complete = 1 for exactly this one cycle.
    - arm=1 -> PRE_HI, with p_azmux_*/p_pc_sel re-latched.
    - arm=0 -> IDLE.
- Handshake:
  - adc_measure_valid is honoured only in SMP_* states, and only from the cycle after the trig pulse onwards.
  - Valid in the same cycle as trig, or in any other state, is ignored.
- Arm deassert mid-pair: the current HI+LO pair completes, then DONE -> IDLE. No partial abort.
- Precharge count: count = 0 behaves as 1. The counter saturates and never wraps.
- Async reset mid-operation: all outputs return to reset values immediately and the switches open.
- Switch safety:
  - sw_pc_ctl is 0 in every cycle where azmux changes value; switches never close during a mux transition.
  - p_pc_sel = 2'b11 is legal; both switches close.

Optional Feature:
SA_AZ_TIMEOUT_EN
- Defined:
  - In SMP_* a counter runs from the trig cycle.
  - If valid is not seen within p_clk_timeout cycles: err_timeout sets (sticky until reset_n, or until leaving IDLE with arm rising), and the state goes to IDLE with switches open. No meas_complete.
  - p_clk_timeout = 0 disables the timeout.
- Undefined: no timeout counter; err_timeout is tied 0 and the block waits indefinitely.

Test Plan:
- Reset, arm=0 -> status=0, azmux=0, sw_pc_ctl=0, no trig over 100 cycles.
- Basic pair:
  - Stimulus: precharge=5, hi=4'h1, lo=4'h8, pc_sel=2'b01, arm=1; valid returned 10 cycles after each trig.
  - Response: azmux=1 for 5 cycles with sw=0, then sw=01 with trig at the same cycle; then azmux=8; then meas_complete one pulse; loops to PRE_HI.
- precharge=0 -> PRE_HI lasts exactly 1 cycle; valid asserted in the trig cycle is ignored and only the next-cycle valid advances.
- arm dropped during SMP_HI -> LO half still executes, meas_complete pulses once, then IDLE; azmux=0.
- reset_n low during SMP_LO -> next sampled outputs all 0, status=0; after release with arm=1, restart at PRE_HI.
- With SA_AZ_TIMEOUT_EN: timeout=20, valid never sent -> err_timeout=1 at trig+20 cycles, status=0, sw_pc_ctl=0, no meas_complete.

Source files
------------

// File: rtl/sample_acquisition_az_seq.sv
// Auto-zero acquisition sequencer: HI/LO az-mux halves with precharge dwell.
// Optional sample timeout: define SA_AZ_TIMEOUT_EN.
module sample_acquisition_az_seq #(
  parameter int PC_CNT_W  = 24,
  parameter int AZ_W      = 4,
  parameter int TIMEOUT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic [PC_CNT_W-1:0]  p_clk_count_precharge,
  input  logic [AZ_W-1:0]      p_azmux_hi,
  input  logic [AZ_W-1:0]      p_azmux_lo,
  input  logic [1:0]           p_pc_sel,
  input  logic [TIMEOUT_W-1:0] p_clk_timeout,
  input  logic                 adc_measure_valid,
  output logic                 adc_measure_trig,
  output logic [AZ_W-1:0]      azmux,
  output logic [1:0]           sw_pc_ctl,
  output logic                 meas_complete,
  output logic                 az_half,
  output logic [2:0]           status,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_HI = 3'd1,
    SMP_HI = 3'd2,
    PRE_LO = 3'd3,
    SMP_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [PC_CNT_W-1:0] pc_q, pc_d;
  logic [AZ_W-1:0]     hi_q, hi_d;
  logic [AZ_W-1:0]     lo_q, lo_d;
  logic [AZ_W-1:0]     azmux_d;
  logic [1:0]          sel_q, sel_d, sw_d;
  logic                latch, half_d;
  logic                trig_d, mc_d;
  logic                valid_ok, tmo_hit;
  logic                smp_d;

  // trig marks the first sample cycle; valid there is too early
  assign valid_ok = adc_measure_valid && !adc_measure_trig;
  assign status   = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    latch   = 1'b0;
    half_d  = az_half;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = PRE_HI;
          latch   = 1'b1;
        end
      end
      PRE_HI: begin
        if (pc_q <= PC_CNT_W'(1)) state_d = SMP_HI;
        else pc_d = pc_q - 1'b1;
      end
      SMP_HI: begin
        if (valid_ok) begin
          state_d = PRE_LO;
          half_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      PRE_LO: begin
        if (pc_q <= PC_CNT_W'(1)) state_d = SMP_LO;
        else pc_d = pc_q - 1'b1;
      end
      SMP_LO: begin
        if (valid_ok) begin
          state_d = DONE;
          half_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (arm) begin
          state_d = PRE_HI;
          latch   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == PRE_HI && state_q != PRE_HI) ||
        (state_d == PRE_LO && state_q != PRE_LO))
      pc_d = p_clk_count_precharge;

    hi_d  = latch ? p_azmux_hi : hi_q;
    lo_d  = latch ? p_azmux_lo : lo_q;
    sel_d = latch ? p_pc_sel   : sel_q;

    // outputs are computed for the next state so they register in step
    smp_d   = (state_d == SMP_HI) || (state_d == SMP_LO);
    azmux_d = '0;
    unique case (state_d)
      PRE_HI, SMP_HI:       azmux_d = hi_d;
      PRE_LO, SMP_LO, DONE: azmux_d = lo_d;
      default:              azmux_d = '0;
    endcase
    sw_d   = smp_d ? sel_d : 2'b00;
    trig_d = smp_d && (state_d != state_q);
    mc_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      pc_q             <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      sel_q            <= '0;
      azmux            <= '0;
      sw_pc_ctl        <= '0;
      adc_measure_trig <= 1'b0;
      meas_complete    <= 1'b0;
      az_half          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      hi_q             <= hi_d;
      lo_q             <= lo_d;
      sel_q            <= sel_d;
      azmux            <= azmux_d;
      sw_pc_ctl        <= sw_d;
      adc_measure_trig <= trig_d;
      meas_complete    <= mc_d;
      az_half          <= half_d;
    end
  end

`ifdef SA_AZ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt_q;
  logic                 arm_q;

  assign tmo_hit = (p_clk_timeout != '0) &&
                   (tcnt_q >= p_clk_timeout - 1'b1);

  // only a timeout takes a sample state straight back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q      <= '0;
      arm_q       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      arm_q <= arm;
      if (trig_d) tcnt_q <= '0;
      else if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
      if ((state_q == SMP_HI || state_q == SMP_LO) &&
          state_d == IDLE)
        err_timeout <= 1'b1;
      else if (state_q == IDLE && arm && !arm_q)
        err_timeout <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^p_clk_timeout;
  assign tmo_hit        = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_sample_acquisition_az_seq.sv
// Scoreboard bench for sample_acquisition_az_seq.
// Expected trig/complete events are queued; a monitor pops and compares.
module tb_sample_acquisition_az_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm;
  logic [23:0] p_clk_count_precharge;
  logic [3:0]  p_azmux_hi, p_azmux_lo;
  logic [1:0]  p_pc_sel;
  logic [31:0] p_clk_timeout;
  logic        adc_measure_valid;
  logic        adc_measure_trig;
  logic [3:0]  azmux;
  logic [1:0]  sw_pc_ctl;
  logic        meas_complete;
  logic        az_half;
  logic [2:0]  status;
  logic        err_timeout;

  sample_acquisition_az_seq dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .arm                   (arm),
    .p_clk_count_precharge (p_clk_count_precharge),
    .p_azmux_hi            (p_azmux_hi),
    .p_azmux_lo            (p_azmux_lo),
    .p_pc_sel              (p_pc_sel),
    .p_clk_timeout         (p_clk_timeout),
    .adc_measure_valid     (adc_measure_valid),
    .adc_measure_trig      (adc_measure_trig),
    .azmux                 (azmux),
    .sw_pc_ctl             (sw_pc_ctl),
    .meas_complete         (meas_complete),
    .az_half               (az_half),
    .status                (status),
    .err_timeout           (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int st;
    int az;
    int sw;
    int half;
    int gap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   nev = 0;
  int   adc_delay = 10;
  bit   adc_early = 0;
  bit   adc_en = 1;
  logic [3:0] prev_az = '0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(int kind, int st, int az, int sw,
                      int half, int gap);
    exp_t e;
    e.kind = kind;
    e.st   = st;
    e.az   = az;
    e.sw   = sw;
    e.half = half;
    e.gap  = gap;
    q.push_back(e);
  endtask

  task automatic wait_ev(int n, int budget);
    int k = 0;
    while (nev < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("event_wait", int'(nev >= n), 1);
  endtask

  task automatic idle_chk(string tag);
    chk({tag, "_status"}, int'(status), 0);
    chk({tag, "_azmux"}, int'(azmux), 0);
    chk({tag, "_sw"}, int'(sw_pc_ctl), 0);
  endtask

  always @(posedge clk) cyc++;

  // ADC model: valid adc_delay cycles after trig, optionally also in trig cycle
  initial begin
    adc_measure_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_measure_trig && adc_en) begin
        if (adc_early) begin
          adc_measure_valid = 1'b1;
          @(negedge clk);
          adc_measure_valid = 1'b0;
          repeat (adc_delay - 1) @(negedge clk);
        end else begin
          repeat (adc_delay) @(negedge clk);
        end
        adc_measure_valid = 1'b1;
        @(negedge clk);
        adc_measure_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (azmux != prev_az) chk("switch_safety", int'(sw_pc_ctl), 0);
      prev_az = azmux;
      if (adc_measure_trig || meas_complete) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("ev_kind", int'(meas_complete), e.kind);
          chk("ev_status", int'(status), e.st);
          chk("ev_half", int'(az_half), e.half);
          chk("ev_gap", cyc - last_cyc, e.gap);
          if (e.kind == 0) begin
            chk("ev_azmux", int'(azmux), e.az);
            chk("ev_sw", int'(sw_pc_ctl), e.sw);
          end
        end
        last_cyc = cyc;
        nev++;
      end
    end
  end

  initial begin
    int b;
    reset_n = 1'b0;
    arm = 1'b0;
    p_clk_count_precharge = 24'd5;
    p_azmux_hi = 4'h1;
    p_azmux_lo = 4'h8;
    p_pc_sel = 2'b01;
    p_clk_timeout = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    idle_chk("reset");
    chk("reset_trig", int'(adc_measure_trig), 0);
    chk("reset_mc", int'(meas_complete), 0);
    chk("reset_half", int'(az_half), 0);
    chk("reset_err", int'(err_timeout), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_events", nev, 0);
    idle_chk("idle100");

    // basic pair, then loop, then arm drop mid SMP_HI
    b = nev;
    push(0, 2, 1, 1, 0, 6);
    push(0, 4, 8, 1, 1, 16);
    push(1, 5, 0, 0, 0, 11);
    push(0, 2, 1, 1, 0, 6);
    last_cyc = cyc;
    arm = 1'b1;
    wait_ev(b + 4, 200);
    arm = 1'b0;
    p_azmux_lo = 4'h3;
    push(0, 4, 8, 1, 1, 16);
    push(1, 5, 0, 0, 0, 11);
    wait_ev(b + 6, 200);
    repeat (5) @(negedge clk);
    #1;
    idle_chk("drop_idle");

    // zero precharge, valid also in trig cycle, both switches
    b = nev;
    p_clk_count_precharge = 24'd0;
    p_azmux_hi = 4'h2;
    p_azmux_lo = 4'h5;
    p_pc_sel = 2'b11;
    adc_early = 1'b1;
    adc_delay = 1;
    @(negedge clk);
    push(0, 2, 2, 3, 0, 2);
    push(0, 4, 5, 3, 1, 3);
    push(1, 5, 0, 0, 0, 2);
    last_cyc = cyc;
    arm = 1'b1;
    wait_ev(b + 1, 50);
    arm = 1'b0;
    wait_ev(b + 3, 50);
    repeat (3) @(negedge clk);
    #1;
    idle_chk("pc0_idle");

    // async reset during SMP_LO then restart
    b = nev;
    adc_early = 1'b0;
    adc_delay = 10;
    p_clk_count_precharge = 24'd3;
    p_azmux_hi = 4'h1;
    p_azmux_lo = 4'h8;
    p_pc_sel = 2'b10;
    @(negedge clk);
    push(0, 2, 1, 2, 0, 4);
    push(0, 4, 8, 2, 1, 14);
    last_cyc = cyc;
    arm = 1'b1;
    wait_ev(b + 2, 100);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    idle_chk("rst_mid");
    chk("rst_mid_trig", int'(adc_measure_trig), 0);
    chk("rst_mid_mc", int'(meas_complete), 0);
    chk("rst_mid_half", int'(az_half), 0);
    repeat (15) @(negedge clk);
    push(0, 2, 1, 2, 0, 4);
    last_cyc = cyc;
    reset_n = 1'b1;
    wait_ev(b + 3, 50);
    arm = 1'b0;
    push(0, 4, 8, 2, 1, 14);
    push(1, 5, 0, 0, 0, 11);
    wait_ev(b + 5, 100);
    repeat (3) @(negedge clk);
    #1;
    idle_chk("restart_idle");

`ifdef SA_AZ_TIMEOUT_EN
    // ADC silent: timeout after 20 cycles from trig
    b = nev;
    adc_en = 1'b0;
    p_clk_timeout = 32'd20;
    p_clk_count_precharge = 24'd1;
    p_pc_sel = 2'b01;
    @(negedge clk);
    push(0, 2, 1, 1, 0, 2);
    last_cyc = cyc;
    arm = 1'b1;
    wait_ev(b + 1, 50);
    repeat (19) @(negedge clk);
    chk("to_err_before", int'(err_timeout), 0);
    @(negedge clk);
    chk("to_err", int'(err_timeout), 1);
    chk("to_status", int'(status), 0);
    chk("to_sw", int'(sw_pc_ctl), 0);
    arm = 1'b0;
    repeat (10) @(negedge clk);
    chk("to_no_mc", nev, b + 1);
    chk("to_err_sticky", int'(err_timeout), 1);
    p_clk_timeout = 32'd0;
    adc_en = 1'b1;
`endif

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
